// File: rtl/sr_latch_pkg.sv
// Shared definitions for the SR latch write arbiter: FSM states, fixed phase
// lengths and the address-width helper.
package sr_latch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int SETUP_CYCLES = 1;
  localparam int HOLD_CYCLES  = 1;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin pick: ptr names the requester that wins a tie; a lone
// request always wins.
module rr_arb_2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
    else              gnt = req;
  end

endmodule

// File: rtl/sr_latch_wr_arb.sv
// Arbitrates two writers onto a bank of gated SR latches with a
// SETUP / PULSE / HOLD sequence. Define SR_LATCH_WR_ARB_READBACK_EN to check i_Q in HOLD.
module sr_latch_wr_arb
  import sr_latch_pkg::*;
#(
  parameter int N_LATCH   = 8,
  parameter int EN_CYCLES = 2,
  // May be widened beyond clog2(N_LATCH) so out-of-range indexes are expressible.
  parameter int ADDR_W    = addr_w(N_LATCH)
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic [1:0]         i_Req,
  input  logic [ADDR_W-1:0]  i_Addr0,
  input  logic               i_Val0,
  input  logic [ADDR_W-1:0]  i_Addr1,
  input  logic               i_Val1,
  input  logic [N_LATCH-1:0] i_Q,
  output logic [1:0]         o_Gnt,
  output logic [1:0]         o_Done,
  output logic               o_Busy,
  output logic [N_LATCH-1:0] o_En,
  output logic [N_LATCH-1:0] o_S,
  output logic [N_LATCH-1:0] o_R,
  output logic               o_Err
);

  state_t              state;
  logic                ptr;
  logic                win;
  logic [ADDR_W-1:0]   addr_q;
  logic                val_q;
  logic [3:0]          cnt;
  logic [1:0]          arb_gnt;
  logic                sel_win;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_val;
  logic [N_LATCH-1:0]  dec_new;
  logic [N_LATCH-1:0]  dec_q;

  // Out-of-range indexes decode to all-zero, so such writes touch no latch.
  function automatic logic [N_LATCH-1:0] decode(input logic [ADDR_W-1:0] a);
    decode = '0;
    for (int i = 0; i < N_LATCH; i++)
      if (a == ADDR_W'(i)) decode[i] = 1'b1;
  endfunction

  rr_arb_2 u_arb (
    .req (i_Req),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  always_comb begin
    sel_win  = arb_gnt[1];
    sel_addr = sel_win ? i_Addr1 : i_Addr0;
    sel_val  = sel_win ? i_Val1  : i_Val0;
    dec_new  = decode(sel_addr);
    dec_q    = decode(addr_q);
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      win    <= 1'b0;
      addr_q <= '0;
      val_q  <= 1'b0;
      cnt    <= '0;
      o_Gnt  <= '0;
      o_Done <= '0;
      o_Busy <= 1'b0;
      o_En   <= '0;
      o_S    <= '0;
      o_R    <= '0;
    end else begin
      o_Gnt  <= '0;
      o_Done <= '0;
      case (state)
        IDLE: begin
          if (|i_Req) begin
            state  <= SETUP;
            cnt    <= 4'(SETUP_CYCLES - 1);
            win    <= sel_win;
            ptr    <= ~sel_win;
            addr_q <= sel_addr;
            val_q  <= sel_val;
            o_Gnt  <= arb_gnt;
            o_Busy <= 1'b1;
            o_S    <= sel_val ? dec_new : '0;
            o_R    <= sel_val ? '0 : dec_new;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= PULSE;
            cnt   <= 4'(EN_CYCLES - 1);
            o_En  <= dec_q;
          end else cnt <= cnt - 4'd1;
        end
        PULSE: begin
          if (cnt == '0) begin
            state  <= HOLD;
            cnt    <= 4'(HOLD_CYCLES - 1);
            o_En   <= '0;
            o_Done <= win ? 2'b10 : 2'b01;
          end else cnt <= cnt - 4'd1;
        end
        HOLD: begin
          if (cnt == '0) begin
            state  <= IDLE;
            o_Busy <= 1'b0;
            o_S    <= '0;
            o_R    <= '0;
          end else cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SR_LATCH_WR_ARB_READBACK_EN
  logic err_q;
  logic rb_bad;

  // The addressed Q bit must match the written value by the last HOLD cycle.
  assign rb_bad = (|dec_q) && ((|(i_Q & dec_q)) != val_q);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) err_q <= 1'b0;
    else if (state == HOLD && cnt == '0 && rb_bad) err_q <= 1'b1;
  end

  assign o_Err = err_q;
`else
  logic unused_q;
  assign unused_q = ^i_Q;
  assign o_Err    = 1'b0;
`endif

endmodule
